modular_sub_serial: RTL and testbench
=====================================

Name: modular_sub_serial

Overview:
- Limb-serial modular subtractor for the BLS12-381 scalar field: z = (x - y) mod M, with operands 256 bits wide and already reduced (< M).
- Counterpart to the combinational modular adder. It is used on the inverse butterfly / coefficient-subtract path of the polynomial multiplier, where area matters more than throughput.
- Processes one LIMB_WIDTH slice per cycle with a valid/ready handshake on both sides.
- Latency is fixed and independent of the data (constant-time): always one subtract pass, then one correction pass.

Parameters:
- DATA_WIDTH, 256, operand/result width; must be an integer multiple of LIMB_WIDTH.
- LIMB_WIDTH, 64, bits processed per cycle; NL = DATA_WIDTH/LIMB_WIDTH (4 by default).
- M, 256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001, field modulus.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  operands present on x_sub/y_sub.
- in_ready  output  1  block can accept operands.
- x_sub  input  DATA_WIDTH  minuend, < M.
- y_sub  input  DATA_WIDTH  subtrahend, < M.
- out_valid  output  1  z_sub holds a result.
- out_ready  input  1  consumer accepts result.
- z_sub  output  DATA_WIDTH  (x_sub - y_sub) mod M.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; limb counter = 0; borrow = 0; carry = 0.
  - Working registers and z_sub are cleared to 0; out_valid = 0; busy = 0.
  - in_ready = 0 while rst is high, then 1 in the first cycle after deassertion.
- Reset mid-operation aborts the operation with no output produced. Captured operands are discarded.
- in_ready = (state == IDLE) and not rst. The handshake completes on a rising edge with in_valid and in_ready both high.
  - On that edge x_sub and y_sub are captured in full.
  - Later changes on the input pins are ignored until the next handshake.
- States:
  - IDLE: wait for the input handshake, then go to SUB with counter = 0 and borrow = 0.
  - SUB: NL cycles, least-significant limb first.
    - Each cycle: limb_i = x_i - y_i - borrow, computed at LIMB_WIDTH+1 bits. The low LIMB_WIDTH bits are written to the result register; the top bit becomes the next borrow.
    - After limb NL-1, the final borrow is latched as the flag neg. Then carry = 0, counter = 0, go to FIX.
  - FIX: NL cycles, least-significant limb first.
    - Each cycle: limb_i = d_i + (neg ? M_i : 0) + carry, computed at LIMB_WIDTH+1 bits; the top bit becomes carry.
    - The final carry is discarded (result is modulo 2^DATA_WIDTH).
    - FIX runs even when neg = 0, so timing never depends on the data.
    - After limb NL-1, go to DONE.
  - DONE: out_valid = 1, busy = 1, in_ready = 0.
    - z_sub is stable until the output handshake. On a rising edge with out_ready = 1: out_valid goes to 0 and the block returns to IDLE.
- z_sub is updated only on the transition into DONE. Its value persists in IDLE until the next result.
- Latency: the input handshake is on edge E. out_valid is first high after edge E + 2*NL (8 cycles with defaults).
  - Back-to-back operation with out_ready held at 1 gives one result per 2*NL+2 cycles.
  - There is no input/output overlap. A request presented in the same cycle the output handshake completes is accepted on the next edge.
- Out-of-range operands (≥ M) are not detected. The output is the raw algorithm result; no error is flagged.
- Static check: if DATA_WIDTH % LIMB_WIDTH != 0, elaboration must fail.

Test Plan:
- Basic subtract, no wrap: x=5, y=3, out_ready=1.
  - Expect z=2 with out_valid high exactly 8 cycles after the accept edge.
  - busy high throughout; in_ready low until the cycle after the output handshake.
- Negative wrap: x=3, y=5.
  - Expect z = 0x73eda753299d7d483339d80809a1d80553bda402fffe5bfefffffffeffffffff (M-2).
  - Latency identical to the basic case (8 cycles).
- Boundaries:
  - x=y=0x1234 → 0.
  - x=0, y=M-1 → 1.
  - x=M-1, y=0 → M-1.
  - Each result in exactly 8 cycles.
- Cross-limb borrow: x = 2^64, y = 1.
  - Expect z = 0x000...0000FFFFFFFFFFFFFFFF; upper three limbs are 0.
- Backpressure: complete a result, hold out_ready=0 for 5 cycles while toggling in_valid and changing x_sub/y_sub.
  - z_sub and out_valid stay stable; in_ready stays 0; no new operands are captured.
  - Raise out_ready: one handshake, then IDLE.
- Reset mid-operation: assert rst during the 2nd SUB cycle, asynchronously (between clock edges).
  - out_valid=0, busy=0, z_sub=0 immediately.
  - After deassertion, in_ready=1.
  - A fresh request x=10, y=4 yields 6 with normal latency.

Source files
------------

// File: rtl/modular_sub_serial.sv
// -----------------------------------------------------------------------------
// modular_sub_serial
//   Limb-serial modular subtractor: z = (x - y) mod M for operands already
//   reduced below M. One LIMB_WIDTH slice is processed per clock. Every
//   operation takes one subtract pass (NL cycles) and then one correction pass
//   (NL cycles). The correction pass runs even when no correction is needed,
//   so latency never depends on the data.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operands present on x_sub / y_sub
//   in_ready   block idle and able to accept operands
//   x_sub      minuend (< M)
//   y_sub      subtrahend (< M)
//   out_valid  z_sub holds a result
//   out_ready  consumer accepts the result
//   z_sub      (x_sub - y_sub) mod M, held until the next result
//   busy       high whenever the block is not idle
// -----------------------------------------------------------------------------
module modular_sub_serial #(
  parameter int                    DATA_WIDTH = 256,
  parameter int                    LIMB_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] M          =
    256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] x_sub,
  input  logic [DATA_WIDTH-1:0] y_sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] z_sub,
  output logic                  busy
);

  localparam int NL = DATA_WIDTH / LIMB_WIDTH;
  localparam int CW = (NL > 1) ? $clog2(NL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NL - 1);

  // Refuse to elaborate when the operand does not split into whole limbs.
  generate
    if (DATA_WIDTH % LIMB_WIDTH != 0) begin : g_bad_width
      $error("modular_sub_serial: DATA_WIDTH must be a multiple of LIMB_WIDTH");
    end
  endgenerate

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SUB  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]            state_q,  state_d;
  logic [CW-1:0]         cnt_q,    cnt_d;
  logic                  borrow_q, borrow_d;
  logic                  carry_q,  carry_d;
  logic                  neg_q,    neg_d;
  logic [DATA_WIDTH-1:0] x_q,      x_d;
  logic [DATA_WIDTH-1:0] y_q,      y_d;
  logic [DATA_WIDTH-1:0] d_q,      d_d;   // difference, corrected in place
  logic [DATA_WIDTH-1:0] z_q,      z_d;

  logic [LIMB_WIDTH-1:0] x_limb, y_limb, d_limb, m_limb, add_limb;
  logic [LIMB_WIDTH:0]   sub_res, fix_res;

  // Current limb slices, selected by the shared limb counter.
  assign x_limb = x_q[cnt_q*LIMB_WIDTH +: LIMB_WIDTH];
  assign y_limb = y_q[cnt_q*LIMB_WIDTH +: LIMB_WIDTH];
  assign d_limb = d_q[cnt_q*LIMB_WIDTH +: LIMB_WIDTH];
  assign m_limb = M[cnt_q*LIMB_WIDTH +: LIMB_WIDTH];

  // Add back M only when the raw difference went negative.
  assign add_limb = neg_q ? m_limb : '0;

  // One extra bit on top: for the subtract it captures the borrow out,
  // for the correction it captures the carry out.
  assign sub_res = {1'b0, x_limb} - {1'b0, y_limb} - {{LIMB_WIDTH{1'b0}}, borrow_q};
  assign fix_res = {1'b0, d_limb} + {1'b0, add_limb} + {{LIMB_WIDTH{1'b0}}, carry_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    carry_d  = carry_q;
    neg_d    = neg_q;
    x_d      = x_q;
    y_d      = y_q;
    d_d      = d_q;
    z_d      = z_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d      = x_sub;
          y_d      = y_sub;
          cnt_d    = '0;
          borrow_d = 1'b0;
          state_d  = S_SUB;
        end
      end

      S_SUB: begin
        d_d[cnt_q*LIMB_WIDTH +: LIMB_WIDTH] = sub_res[LIMB_WIDTH-1:0];
        borrow_d = sub_res[LIMB_WIDTH];
        if (cnt_q == CNT_LAST) begin
          neg_d   = sub_res[LIMB_WIDTH];
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_FIX: begin
        d_d[cnt_q*LIMB_WIDTH +: LIMB_WIDTH] = fix_res[LIMB_WIDTH-1:0];
        // The final carry out of the top limb is dropped (mod 2^DATA_WIDTH).
        carry_d = fix_res[LIMB_WIDTH];
        if (cnt_q == CNT_LAST) begin
          z_d     = d_d;      // includes the limb written this cycle
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin // S_DONE
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      carry_q  <= 1'b0;
      neg_q    <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      d_q      <= '0;
      z_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      carry_q  <= carry_d;
      neg_q    <= neg_d;
      x_q      <= x_d;
      y_q      <= y_d;
      d_q      <= d_d;
      z_q      <= z_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign z_sub     = z_q;

endmodule

// File: tb/tb_modular_sub_serial.sv
module tb_modular_sub_serial;

  localparam logic [255:0] MOD =
    256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001;
  localparam logic [255:0] MOD_M1 =
    256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000000;
  localparam logic [255:0] MOD_M2 =
    256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfefffffffeffffffff;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] x_sub;
  logic [255:0] y_sub;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] z_sub;
  logic         busy;

  modular_sub_serial dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_sub     (x_sub),
    .y_sub     (y_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z_sub     (z_sub),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] x;
    logic [255:0] y;
    logic [255:0] z;
    int           hold;
    string        name;
  } vec_t;

  vec_t         vecs[7];
  logic [255:0] exp_q[$];
  int           passed = 0;
  int           total  = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Random operand strictly below the modulus (top two bits cleared).
  function automatic logic [255:0] rand_op();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    v[255:254] = 2'b00;
    return v;
  endfunction

  // One full transaction: handshake in, expected pushed to the scoreboard,
  // latency counted, result popped and compared, optional backpressure.
  task automatic do_op(input logic [255:0] x, input logic [255:0] y,
                       input logic [255:0] zexp, input int hold, input string tag);
    int           lat;
    logic         ok;
    logic [255:0] zgot;
    logic [255:0] zref;
    @(negedge clk);
    out_ready = (hold == 0);
    lat = 0;
    while (!in_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_in_ready"}, {255'd0, in_ready}, 256'd1);
    x_sub    = x;
    y_sub    = y;
    in_valid = 1'b1;
    exp_q.push_back(zexp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x_sub    = ~x;        // later pin changes must be ignored
    y_sub    = x;
    ok  = 1'b1;
    lat = 0;
    while (!out_valid && lat < 50) begin
      if (!busy || in_ready) ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_busy_while_running"}, {255'd0, ok}, 256'd1);
    check({tag, "_latency"}, 256'(lat), 256'd8);
    zgot = z_sub;
    zref = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    check({tag, "_z"}, zgot, zref);
    if (hold > 0) begin
      ok = 1'b1;
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        in_valid = ~in_valid;
        x_sub    = rand_op();
        y_sub    = rand_op();
        @(posedge clk);
        #1;
        if (z_sub !== zgot || !out_valid || in_ready || !busy) ok = 1'b0;
      end
      check({tag, "_backpressure_stable"}, {255'd0, ok}, 256'd1);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, "_after_out_hs"}, {253'd0, out_valid, busy, in_ready}, 256'd1);
    check({tag, "_z_persists"}, z_sub, zgot);
    $display("txn %s x=%h y=%h z=%h lat=%0d", tag, x, y, zgot, lat);
  endtask

  initial begin
    vecs[0] = '{x: 256'd5,         y: 256'd3,      z: 256'd2,      hold: 0, name: "basic"};
    vecs[1] = '{x: 256'd3,         y: 256'd5,      z: MOD_M2,      hold: 0, name: "neg_wrap"};
    vecs[2] = '{x: 256'h1234,      y: 256'h1234,   z: 256'd0,      hold: 0, name: "equal"};
    vecs[3] = '{x: 256'd0,         y: MOD_M1,      z: 256'd1,      hold: 0, name: "zero_minus_max"};
    vecs[4] = '{x: MOD_M1,         y: 256'd0,      z: MOD_M1,      hold: 0, name: "max_minus_zero"};
    vecs[5] = '{x: 256'h1_0000_0000_0000_0000, y: 256'd1,
                z: 256'hFFFF_FFFF_FFFF_FFFF, hold: 0, name: "cross_limb"};
    vecs[6] = '{x: 256'd100,       y: 256'd1,      z: 256'd99,     hold: 5, name: "backpressure"};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x_sub     = '0;
    y_sub     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready",  {255'd0, in_ready},  256'd0);
    check("reset_out_valid", {255'd0, out_valid}, 256'd0);
    check("reset_busy",      {255'd0, busy},      256'd0);
    check("reset_z",         z_sub,               256'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_in_ready", {255'd0, in_ready}, 256'd1);

    for (int i = 0; i < 7; i++)
      do_op(vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].hold, vecs[i].name);

    for (int i = 0; i < 3; i++) begin
      logic [255:0] a, b, e;
      a = rand_op();
      b = rand_op();
      e = (a >= b) ? (a - b) : (MOD - (b - a));
      do_op(a, b, e, 0, $sformatf("random%0d", i));
    end

    // Reset asserted between edges during the second SUB cycle.
    @(negedge clk);
    x_sub    = 256'd7;
    y_sub    = 256'd2;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midop_rst_out_valid", {255'd0, out_valid}, 256'd0);
    check("midop_rst_busy",      {255'd0, busy},      256'd0);
    check("midop_rst_z",         z_sub,               256'd0);
    check("midop_rst_in_ready",  {255'd0, in_ready},  256'd0);
    #2;
    rst = 1'b0;
    #1;
    check("midop_release_in_ready", {255'd0, in_ready}, 256'd1);
    $display("txn reset_abort x=%h y=%h (aborted)", 256'd7, 256'd2);
    do_op(256'd10, 256'd4, 256'd6, 0, "after_reset");

    check("scoreboard_empty", 256'(exp_q.size()), 256'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
